sisc_ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the SISC datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and decodes the 32-bit instruction register into per-cycle datapath enables: PC, IR, register file, ALU, status register and data memory. It stalls on a data-memory ready handshake, halts on HLT or a memory timeout, and counts retired instructions.

---
 rtl/sisc_ctrl_seq.sv | 194 +++++++++++++++++++
 tb/tb_sisc_ctrl_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ctrl_seq.sv
// Multi-cycle control sequencer for the SISC datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, decodes the
// instruction register into per-cycle datapath enables, stalls on the data
// memory ready handshake, halts on HLT or a memory timeout and counts
// retired instructions.
module sisc_ctrl_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      ir,
  input  logic [3:0]       stat,
  input  logic             mem_rdy,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             stat_en,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             halted,
  output logic             mem_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TW-1:0]    r_wait;
  logic             r_halted;
  logic             r_mem_err;

  logic [3:0] w_op;
  logic [3:0] w_mm;
  logic [2:0] w_fn;
  logic       w_is_lod;
  logic       w_is_str;
  logic       w_is_bra;
  logic       w_is_alu;
  logic       w_is_hlt;
  logic       w_is_illegal;
  logic       w_br_taken;
  logic       w_timeout;
  logic       w_unused_ir;

  assign w_op = ir[31:28];
  assign w_mm = ir[27:24];
  assign w_fn = ir[2:0];

  // Register/immediate fields are consumed by the datapath, not here.
  assign w_unused_ir = ^ir[23:3];

  assign w_is_lod     = (w_op == 4'h2);
  assign w_is_str     = (w_op == 4'h3);
  assign w_is_bra     = (w_op == 4'h4);
  assign w_is_alu     = (w_op == 4'h8);
  assign w_is_hlt     = (w_op == 4'hF);
  assign w_is_illegal = !(w_op == 4'h0 || w_is_lod || w_is_str ||
                          w_is_bra || w_is_alu || w_is_hlt);

  // Unconditional when mm is zero, otherwise any selected flag set.
  assign w_br_taken = (w_mm == 4'h0) || ((w_mm & stat) != 4'h0);

  // Last permitted wait cycle elapsing without ready.
  assign w_timeout = !mem_rdy && (r_wait == TO_LAST);

  // State sequencing, wait counter, sticky flags and retire counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_halted  <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_hlt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_alu) begin
            r_state <= S_WB;
          end else if (w_is_lod || w_is_str) begin
            r_state <= S_MEM;
            r_wait  <= '0;
          end else begin
            r_state <= S_FETCH;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_MEM: begin
          if (mem_rdy) begin
            if (w_is_lod) begin
              r_state <= S_WB;
            end else begin
              r_state <= S_FETCH;
              r_cnt   <= r_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_mem_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_cnt   <= r_cnt + 1'b1;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Per-state datapath enables; everything but state/count is held low in reset.
  always_comb begin
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    alu_src  = 1'b0;
    alu_op   = 3'b000;
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    illegal  = 1'b0;
    if (!RST) begin
      case (r_state)
        S_FETCH: begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
        S_EXEC: begin
          if (w_is_alu) begin
            alu_src = w_mm[3];
            alu_op  = w_mm[3] ? 3'b001 : w_fn;
            stat_en = 1'b1;
          end else if (w_is_lod || w_is_str) begin
            alu_src = 1'b1;
            alu_op  = 3'b001;
          end else if (w_is_bra) begin
            pc_write = w_br_taken;
            pc_sel   = w_br_taken;
          end else begin
            illegal = w_is_illegal;
          end
        end
        S_MEM: begin
          mem_rd = w_is_lod;
          mem_wr = w_is_str;
        end
        S_WB: begin
          rf_we  = 1'b1;
          wb_sel = w_is_lod;
        end
        default: begin
        end
      endcase
    end
  end

  assign halted    = r_halted && !RST;
  assign mem_err   = r_mem_err && !RST;
  assign instr_cnt = r_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_sisc_ctrl_seq.sv
// Randomised bench for sisc_ctrl_seq: each instruction is expanded into its
// expected per-cycle trace (state, enables, retire count) and compared cycle
// by cycle against the DUT.
module tb_sisc_ctrl_seq;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  localparam int B_IRL  = 14;
  localparam int B_PCW  = 13;
  localparam int B_PCS  = 12;
  localparam int B_ASRC = 11;
  localparam int B_STEN = 7;
  localparam int B_RFWE = 6;
  localparam int B_WBS  = 5;
  localparam int B_MRD  = 4;
  localparam int B_MWR  = 3;
  localparam int B_HLT  = 2;
  localparam int B_MERR = 1;
  localparam int B_ILL  = 0;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [31:0]      ir = 32'h0;
  logic [3:0]       stat = 4'h0;
  logic             mem_rdy = 1'b0;
  logic             ir_load, pc_write, pc_sel, alu_src, stat_en, rf_we, wb_sel;
  logic             mem_rd, mem_wr, halted, mem_err, illegal;
  logic [2:0]       alu_op;
  logic [CNT_W-1:0] instr_cnt;
  logic [2:0]       state;
  logic [14:0]      obs_vec;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt    = 0;

  int          q_state[$];
  logic [14:0] q_out[$];
  int          q_rdy[$];

  sisc_ctrl_seq #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ir(ir), .stat(stat), .mem_rdy(mem_rdy),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel),
    .alu_src(alu_src), .alu_op(alu_op), .stat_en(stat_en), .rf_we(rf_we),
    .wb_sel(wb_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted),
    .mem_err(mem_err), .illegal(illegal), .instr_cnt(instr_cnt), .state(state)
  );

  assign obs_vec = {ir_load, pc_write, pc_sel, alu_src, alu_op, stat_en, rf_we,
                    wb_sel, mem_rd, mem_wr, halted, mem_err, illegal};

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input int st, input logic [14:0] o, input int rdy);
    q_state.push_back(st);
    q_out.push_back(o);
    q_rdy.push_back(rdy);
  endtask

  // Expected cycle trace of one instruction; rdy code 2 means "don't care".
  task automatic build(input logic [31:0] i_ir, input logic [3:0] i_stat, input int w,
                       output bit counted, output bit ends_halt);
    logic [3:0]  op;
    logic [3:0]  mm;
    logic [14:0] o;
    logic [14:0] om;
    bit          taken;
    op = i_ir[31:28];
    mm = i_ir[27:24];
    counted = 1'b1;
    ends_halt = 1'b0;
    o = '0; o[B_IRL] = 1'b1; o[B_PCW] = 1'b1;
    push(0, o, 2);
    push(1, 15'h0, 2);
    case (op)
      4'hF: begin
        counted = 1'b0;
        ends_halt = 1'b1;
        o = '0; o[B_HLT] = 1'b1;
        for (int k = 0; k < 3; k++) push(5, o, 2);
      end
      4'h8: begin
        o = '0;
        o[B_ASRC] = mm[3];
        o[10:8] = mm[3] ? 3'b001 : i_ir[2:0];
        o[B_STEN] = 1'b1;
        push(2, o, 2);
        o = '0; o[B_RFWE] = 1'b1;
        push(4, o, 2);
      end
      4'h2, 4'h3: begin
        o = '0; o[B_ASRC] = 1'b1; o[10:8] = 3'b001;
        push(2, o, 2);
        om = '0;
        if (op == 4'h2) om[B_MRD] = 1'b1; else om[B_MWR] = 1'b1;
        if (w < MEM_TIMEOUT) begin
          for (int k = 0; k <= w; k++) push(3, om, (k < w) ? 0 : 1);
          if (op == 4'h2) begin
            o = '0; o[B_RFWE] = 1'b1; o[B_WBS] = 1'b1;
            push(4, o, 2);
          end
        end else begin
          counted = 1'b0;
          ends_halt = 1'b1;
          for (int k = 0; k < MEM_TIMEOUT; k++) push(3, om, 0);
          o = '0; o[B_HLT] = 1'b1; o[B_MERR] = 1'b1;
          for (int k = 0; k < 3; k++) push(5, o, 2);
        end
      end
      4'h4: begin
        taken = (mm == 4'h0) || ((mm & i_stat) != 4'h0);
        o = '0; o[B_PCW] = taken; o[B_PCS] = taken;
        push(2, o, 2);
      end
      default: begin
        o = '0; o[B_ILL] = (op != 4'h0);
        push(2, o, 2);
      end
    endcase
  endtask

  // Replays up to max_len cycles of the queued trace, then drops the rest.
  task automatic run_trace(input int max_len);
    int n;
    n = (q_state.size() < max_len) ? q_state.size() : max_len;
    for (int c = 0; c < n; c++) begin
      mem_rdy = (q_rdy[c] == 2) ? 1'($urandom_range(0, 1)) : 1'(q_rdy[c]);
      @(negedge CLK);
      check_val("state", 32'(state), 32'(q_state[c]));
      check_val("outs", 32'(obs_vec), 32'(q_out[c]));
      check_val("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
      @(posedge CLK);
      #1;
    end
    q_state.delete();
    q_out.delete();
    q_rdy.delete();
  endtask

  task automatic do_reset(input int pre_state);
    RST = 1'b1;
    mem_rdy = 1'($urandom_range(0, 1));
    @(negedge CLK);
    check_val("rst_outs", 32'(obs_vec), 32'h0);
    check_val("rst_state_pre", 32'(state), 32'(pre_state));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    m_cnt = 0;
    check_val("rst_state", 32'(state), 32'h0);
    check_val("rst_cnt", 32'(instr_cnt), 32'h0);
  endtask

  task automatic run_instr(input int idx, input logic [31:0] i_ir, input logic [3:0] i_stat,
                           input int w, input int max_len);
    bit counted;
    bit ends_halt;
    int len;
    ir = i_ir;
    stat = i_stat;
    build(i_ir, i_stat, w, counted, ends_halt);
    len = q_state.size();
    $display("txn %0d: ir=%08h stat=%h w=%0d cycles=%0d cnt=%0d", idx, i_ir, i_stat, w,
             (len < max_len) ? len : max_len, m_cnt);
    run_trace(max_len);
    if (max_len >= len) begin
      if (counted) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (ends_halt) do_reset(5);
    end
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] iv;
    logic [3:0]  op;
    int          r;
    int          w;

    RST = 1'b1;
    @(negedge CLK);
    check_val("init_outs", 32'(obs_vec), 32'h0);
    check_val("init_state", 32'(state), 32'h0);
    check_val("init_cnt", 32'(instr_cnt), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Directed examples first, then random traffic.
    run_instr(0, 32'h00000000, 4'h0, 0, 1000);
    run_instr(1, 32'h8801000A, 4'h0, 0, 1000);
    run_instr(2, 32'h80213002, 4'h0, 0, 1000);
    run_instr(3, 32'h41000005, 4'h1, 0, 1000);
    run_instr(4, 32'h41000005, 4'h0, 0, 1000);
    run_instr(5, 32'h40000005, 4'h0, 0, 1000);
    run_instr(6, 32'h20100004, 4'h0, 3, 1000);
    run_instr(7, 32'h30100004, 4'h0, 0, 1000);
    run_instr(8, 32'h70000000, 4'h0, 0, 1000);
    run_instr(9, 32'h20100004, 4'h0, 14, 1000);
    run_instr(10, 32'h20100004, 4'h0, 15, 1000);
    run_instr(11, 32'hF0000000, 4'h0, 0, 1000);

    for (int n = 12; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 12) op = 4'h0;
      else if (r < 32) op = 4'h8;
      else if (r < 50) op = 4'h2;
      else if (r < 66) op = 4'h3;
      else if (r < 84) op = 4'h4;
      else if (r < 97) begin
        op = 4'(32'($urandom_range(1, 14)));
        while (op == 4'h2 || op == 4'h3 || op == 4'h4 || op == 4'h8)
          op = 4'(32'($urandom_range(1, 14)));
      end else op = 4'hF;
      rnd = $urandom();
      iv = {op, rnd[27:0]};
      if (op == 4'h4 && $urandom_range(0, 3) == 0) iv[27:24] = 4'h0;
      r = $urandom_range(0, 39);
      if (r == 39) w = MEM_TIMEOUT + $urandom_range(0, 3);
      else if (r == 38) w = MEM_TIMEOUT - 1;
      else w = $urandom_range(0, 4);
      run_instr(n, iv, 4'($urandom_range(0, 15)), w, 1000);
    end

    // Reset in the middle of a stalled load.
    run_instr(400, 32'h00000000, 4'h0, 0, 1000);
    run_instr(401, 32'h20100004, 4'h0, 20, 5);
    do_reset(3);
    run_instr(402, 32'h00000000, 4'h0, 0, 1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
